// File: rtl/tank_bullet_pkg.sv
// Shared tank/bullet types and screen geometry, plus spawn and hit-box helpers.
package tank_bullet_pkg;

   localparam int SCREEN_X_MAX    = 639;
   localparam int SCREEN_Y_MAX    = 479;
   localparam int TANK_W          = 32;
   localparam int TANK_H          = 32;
   localparam int BULLET_SIZE     = 4;
   localparam int BULLET_SPEED    = 4;
   localparam int BULLET_COOLDOWN = 30;

   typedef enum logic [2:0] {
      DIR_UP    = 3'd1,
      DIR_RIGHT = 3'd2,
      DIR_LEFT  = 3'd3,
      DIR_DOWN  = 3'd4
   } dir_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLYING   = 2'd1,
      COOLDOWN = 2'd2
   } bullet_state_t;

   typedef struct packed {
      logic       on_screen;
      logic [9:0] x;
      logic [9:0] y;
   } spawn_t;

   // Spawn point at the tank's leading edge; 12-bit math so underflow lands far off screen.
   function automatic spawn_t spawn_pos(logic [9:0] tx, logic [9:0] ty, dir_t dir);
      logic [11:0] x;
      logic [11:0] y;
      spawn_t      s;
      x = {2'b00, tx};
      y = {2'b00, ty};
      case (dir)
         DIR_UP: begin
            x = {2'b00, tx} + 12'(TANK_W/2 - BULLET_SIZE/2);
            y = {2'b00, ty} - 12'(BULLET_SIZE);
         end
         DIR_RIGHT: begin
            x = {2'b00, tx} + 12'(TANK_W);
            y = {2'b00, ty} + 12'(TANK_H/2 - BULLET_SIZE/2);
         end
         DIR_LEFT: begin
            x = {2'b00, tx} - 12'(BULLET_SIZE);
            y = {2'b00, ty} + 12'(TANK_H/2 - BULLET_SIZE/2);
         end
         DIR_DOWN: begin
            x = {2'b00, tx} + 12'(TANK_W/2 - BULLET_SIZE/2);
            y = {2'b00, ty} + 12'(TANK_H);
         end
         default: ;
      endcase
      s.on_screen = (x <= 12'(SCREEN_X_MAX)) && (y <= 12'(SCREEN_Y_MAX));
      s.x         = x[9:0];
      s.y         = y[9:0];
      return s;
   endfunction

   // Bullet box against an opposing tank box.
   function automatic logic boxes_overlap(logic [9:0] bx, logic [9:0] by,
                                          logic [9:0] tx, logic [9:0] ty);
      return ({1'b0, bx} <= {1'b0, tx} + 11'(TANK_W - 1)) &&
             ({1'b0, bx} + 11'(BULLET_SIZE - 1) >= {1'b0, tx}) &&
             ({1'b0, by} <= {1'b0, ty} + 11'(TANK_H - 1)) &&
             ({1'b0, by} + 11'(BULLET_SIZE - 1) >= {1'b0, ty});
   endfunction

endpackage

// File: rtl/tank_bullet_if.sv
// Fire handshake between a tank controller (master) and its bullet engine (slave).
interface tank_bullet_if;
   import tank_bullet_pkg::*;

   logic       fire_req;
   logic [9:0] tank_X;
   logic [9:0] tank_Y;
   logic [2:0] tank_dir;
   logic       fire_ack;
   logic       busy;

   modport master (output fire_req, tank_X, tank_Y, tank_dir, input fire_ack, busy);
   modport slave  (input fire_req, tank_X, tank_Y, tank_dir, output fire_ack, busy);

endinterface

// File: rtl/frame_edge_detect.sv
// Registered rising-edge detect of the frame clock: one Clk wide, one Clk late.
module frame_edge_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic frame_edge
);

   logic frame_prev_q;
   logic frame_edge_q;

   // Remember last sample and flag a low-to-high transition.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         frame_prev_q <= 1'b0;
         frame_edge_q <= 1'b0;
      end else begin
         frame_prev_q <= frame_clk;
         frame_edge_q <= frame_clk & ~frame_prev_q;
      end
   end

   assign frame_edge = frame_edge_q;

endmodule

// File: rtl/tank_bullet.sv
// Bullet engine for one tank: spawn on fire, move per frame, retire at edge or on hit.
// Optional target hit detection is enabled by defining TANK_BULLET_HIT_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | no bullet; waiting for a valid fire request
//   FLYING   | bullet live and drawn; moves Speed pixels per frame edge
//   COOLDOWN | bullet retired; counting frame edges before next shot
module tank_bullet
   import tank_bullet_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_clk,
   tank_bullet_if.slave fire,
   input  logic [9:0]  target_X,
   input  logic [9:0]  target_Y,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   output logic        hit,
   output logic [9:0]  bullet_X,
   output logic [9:0]  bullet_Y,
   output logic        is_bullet
);

   localparam int CNT_W = $clog2(BULLET_COOLDOWN + 1);

   bullet_state_t    state_q;
   dir_t             dir_q;
   logic [9:0]       bullet_X_q;
   logic [9:0]       bullet_Y_q;
   logic [CNT_W-1:0] cool_q;
   logic             fire_ack_q;
   logic             hit_q;

   logic             frame_edge;
   logic             dir_valid;
   spawn_t           spawn;
   logic             exit_edge;
   logic [9:0]       bullet_x_d;
   logic [9:0]       bullet_y_d;
   logic             strike;

   frame_edge_detect u_frame_edge (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_edge (frame_edge)
   );

   assign dir_valid = (fire.tank_dir >= 3'd1) && (fire.tank_dir <= 3'd4);
   assign spawn     = spawn_pos(fire.tank_X, fire.tank_Y, dir_t'(fire.tank_dir));

   // Next position one step ahead, or stay put and flag exit if that step leaves the screen.
   always_comb begin
      exit_edge  = 1'b0;
      bullet_x_d = bullet_X_q;
      bullet_y_d = bullet_Y_q;
      case (dir_q)
         DIR_UP: begin
            if (bullet_Y_q < 10'(BULLET_SPEED)) exit_edge = 1'b1;
            else                                bullet_y_d = bullet_Y_q - 10'(BULLET_SPEED);
         end
         DIR_LEFT: begin
            if (bullet_X_q < 10'(BULLET_SPEED)) exit_edge = 1'b1;
            else                                bullet_x_d = bullet_X_q - 10'(BULLET_SPEED);
         end
         DIR_DOWN: begin
            if ({1'b0, bullet_Y_q} + 11'(BULLET_SIZE + BULLET_SPEED) > 11'(SCREEN_Y_MAX))
               exit_edge = 1'b1;
            else
               bullet_y_d = bullet_Y_q + 10'(BULLET_SPEED);
         end
         DIR_RIGHT: begin
            if ({1'b0, bullet_X_q} + 11'(BULLET_SIZE + BULLET_SPEED) > 11'(SCREEN_X_MAX))
               exit_edge = 1'b1;
            else
               bullet_x_d = bullet_X_q + 10'(BULLET_SPEED);
         end
         default: exit_edge = 1'b1;
      endcase
   end

`ifdef TANK_BULLET_HIT_EN
   assign strike = boxes_overlap(bullet_x_d, bullet_y_d, target_X, target_Y);
`else
   logic unused_target;
   assign strike        = 1'b0;
   assign unused_target = ^{target_X, target_Y};
`endif

   // Bullet lifecycle FSM with registered ack/hit pulses and position.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         dir_q      <= DIR_UP;
         bullet_X_q <= '0;
         bullet_Y_q <= '0;
         cool_q     <= '0;
         fire_ack_q <= 1'b0;
         hit_q      <= 1'b0;
      end else begin
         fire_ack_q <= 1'b0;
         hit_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (fire.fire_req && dir_valid) begin
                  fire_ack_q <= 1'b1;
                  dir_q      <= dir_t'(fire.tank_dir);
                  if (spawn.on_screen) begin
                     bullet_X_q <= spawn.x;
                     bullet_Y_q <= spawn.y;
                     state_q    <= FLYING;
                  end else begin
                     cool_q  <= CNT_W'(BULLET_COOLDOWN);
                     state_q <= COOLDOWN;
                  end
               end
            end
            FLYING: begin
               if (frame_edge) begin
                  if (strike) begin
                     hit_q      <= 1'b1;
                     bullet_X_q <= bullet_x_d;
                     bullet_Y_q <= bullet_y_d;
                     cool_q     <= CNT_W'(BULLET_COOLDOWN);
                     state_q    <= COOLDOWN;
                  end else if (exit_edge) begin
                     cool_q  <= CNT_W'(BULLET_COOLDOWN);
                     state_q <= COOLDOWN;
                  end else begin
                     bullet_X_q <= bullet_x_d;
                     bullet_Y_q <= bullet_y_d;
                  end
               end
            end
            COOLDOWN: begin
               if (frame_edge) begin
                  cool_q <= cool_q - CNT_W'(1);
                  if (cool_q == CNT_W'(1)) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign fire.fire_ack = fire_ack_q;
   assign fire.busy     = (state_q != IDLE);
   assign hit           = hit_q;
   assign bullet_X      = bullet_X_q;
   assign bullet_Y      = bullet_Y_q;

   assign is_bullet = (state_q == FLYING) &&
                      ({1'b0, DrawX} >= {1'b0, bullet_X_q}) &&
                      ({1'b0, DrawX} <= {1'b0, bullet_X_q} + 11'(BULLET_SIZE - 1)) &&
                      ({1'b0, DrawY} >= {1'b0, bullet_Y_q}) &&
                      ({1'b0, DrawY} <= {1'b0, bullet_Y_q} + 11'(BULLET_SIZE - 1));

endmodule

// File: tb/tb_tank_bullet.sv
// Self-checking bench for tank_bullet: directed scenarios plus random shots against a
// pixel-level flight model. Honors TANK_BULLET_HIT_EN the same way as the design.
module tb_tank_bullet;

`ifdef TANK_BULLET_HIT_EN
   localparam bit HIT_EN = 1'b1;
`else
   localparam bit HIT_EN = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_clk;
   logic [9:0] target_X, target_Y, DrawX, DrawY;
   logic       hit, is_bullet;
   logic [9:0] bullet_X, bullet_Y;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0;
   int hit_cnt = 0;

   tank_bullet_if fire ();

   tank_bullet dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .fire      (fire),
      .target_X  (target_X),
      .target_Y  (target_Y),
      .DrawX     (DrawX),
      .DrawY     (DrawY),
      .hit       (hit),
      .bullet_X  (bullet_X),
      .bullet_Y  (bullet_Y),
      .is_bullet (is_bullet)
   );

   always #5 Clk = ~Clk;

   // Count cycles with ack/hit high, sampled well after the clock edge.
   always @(posedge Clk) begin
      #2;
      if (fire.fire_ack === 1'b1) ack_cnt++;
      if (hit === 1'b1) hit_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One frame clock pulse; returns on a falling Clk edge after the design has reacted.
   task automatic tick();
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
   endtask

   // Fire one shot and follow it through flight and cooldown against the model.
   task automatic shoot(input int tx, input int ty, input int dir, input int gx, input int gy,
                        input bit hold, output int n, output int fx, output int fy);
      int  x, y, dx, dy, nx, ny, ack0, hit0, exp_hits;
      bit  live, shown, fits, strike;
      x = tx; y = ty; dx = 0; dy = 0;
      case (dir)
         1: begin x = tx + 14; y = ty - 4;  dy = -1; end
         2: begin x = tx + 32; y = ty + 14; dx = 1;  end
         3: begin x = tx - 4;  y = ty + 14; dx = -1; end
         4: begin x = tx + 14; y = ty + 32; dy = 1;  end
         default: ;
      endcase
      live  = (x >= 0) && (x <= 639) && (y >= 0) && (y <= 479);
      shown = live;
      ack0 = ack_cnt; hit0 = hit_cnt; exp_hits = 0;
      fire.tank_X = 10'(tx); fire.tank_Y = 10'(ty); fire.tank_dir = 3'(dir);
      target_X = 10'(gx); target_Y = 10'(gy);
      fire.fire_req = 1'b1;
      @(negedge Clk);
      chk("ack_on_accept", fire.fire_ack, 1);
      chk("busy_on_accept", fire.busy, 1);
      if (live) begin
         chk("spawn_x", bullet_X, x);
         chk("spawn_y", bullet_Y, y);
      end else begin
         DrawX = bullet_X; DrawY = bullet_Y; #1;
         chk("offscreen_not_drawn", is_bullet, 0);
      end
      fire.fire_req = hold;
      n = 0;
      while (live && n < 300) begin
         tick();
         n++;
         nx = x + 4 * dx; ny = y + 4 * dy;
         fits = (nx >= 0) && (ny >= 0) && (nx + 4 <= 639) && (ny + 4 <= 479);
         if (fits) begin x = nx; y = ny; end
         strike = HIT_EN && (x <= gx + 31) && (x + 3 >= gx) && (y <= gy + 31) && (y + 3 >= gy);
         if (strike) exp_hits++;
         if (strike || !fits) live = 1'b0;
         chk("fly_x", bullet_X, x);
         chk("fly_y", bullet_Y, y);
         chk("fly_busy", fire.busy, 1);
         DrawX = 10'(x + ((n % 2 == 1) ? int'($urandom_range(0, 3)) : 4));
         DrawY = 10'(y + int'($urandom_range(0, 3)));
         #1;
         chk("is_bullet", is_bullet, {31'd0, live && (n % 2 == 1)});
      end
      chk("one_ack_per_shot", ack_cnt - ack0, 1);
      chk("hit_pulses", hit_cnt - hit0, exp_hits);
      fire.fire_req = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         chk("cooldown_busy", fire.busy, {31'd0, i < 30});
         if (i == 1 && shown) begin
            DrawX = 10'(x); DrawY = 10'(y); #1;
            chk("cooldown_hidden", is_bullet, 0);
            chk("cooldown_hold_x", bullet_X, x);
            chk("cooldown_hold_y", bullet_Y, y);
         end
      end
      fx = x; fy = y;
   endtask

   initial begin
      int n, fx, fy, a0;
      Reset = 1'b1; frame_clk = 1'b0;
      fire.fire_req = 1'b0; fire.tank_X = '0; fire.tank_Y = '0; fire.tank_dir = '0;
      target_X = '0; target_Y = '0; DrawX = '0; DrawY = '0;
      repeat (3) @(negedge Clk);
      chk("rst_ack", fire.fire_ack, 0);
      chk("rst_busy", fire.busy, 0);
      chk("rst_hit", hit, 0);
      chk("rst_bx", bullet_X, 0);
      chk("rst_by", bullet_Y, 0);
      chk("rst_isb", is_bullet, 0);
      Reset = 1'b0;
      @(negedge Clk);

      // Single-cycle accept, spawn and first move.
      target_X = 10'd600; target_Y = 10'd0;
      fire.tank_X = 10'd100; fire.tank_Y = 10'd380; fire.tank_dir = 3'd1; fire.fire_req = 1'b1;
      @(negedge Clk);
      chk("t1_ack", fire.fire_ack, 1);
      chk("t1_x", bullet_X, 114);
      chk("t1_y", bullet_Y, 376);
      fire.fire_req = 1'b0;
      @(negedge Clk);
      chk("t1_ack_width", fire.fire_ack, 0);
      tick();
      chk("t1_move_x", bullet_X, 114);
      chk("t1_move_y", bullet_Y, 372);

      // Reset mid-flight, then re-accept with fire_req held through reset.
      tick();
      fire.fire_req = 1'b1;
      Reset = 1'b1;
      DrawX = bullet_X; DrawY = bullet_Y;
      a0 = ack_cnt;
      @(negedge Clk);
      chk("t6_busy", fire.busy, 0);
      chk("t6_bx", bullet_X, 0);
      chk("t6_by", bullet_Y, 0);
      chk("t6_isb", is_bullet, 0);
      chk("t6_ack", fire.fire_ack, 0);
      @(negedge Clk);
      chk("t6_no_ack_in_reset", ack_cnt - a0, 0);
      Reset = 1'b0;
      @(negedge Clk);
      chk("t6_reaccept", fire.fire_ack, 1);
      fire.fire_req = 1'b0;
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);

      // Full up shot: 94 moves to Y=0, retire on edge 95.
      shoot(100, 380, 1, 600, 0, 1'b0, n, fx, fy);
      chk("t2_edges", n, 95);
      chk("t2_final_y", fy, 0);

      // Held request through flight: still one ack.
      shoot(300, 200, 4, 0, 0, 1'b1, n, fx, fy);

      // Off-screen spawn, then invalid direction codes.
      shoot(0, 200, 3, 600, 0, 1'b0, n, fx, fy);
      chk("t4_no_flight", n, 0);
      for (int d = 0; d < 8; d++) begin
         if (d >= 1 && d <= 4) continue;
         a0 = ack_cnt;
         fire.tank_X = 10'd200; fire.tank_Y = 10'd200; fire.tank_dir = 3'(d); fire.fire_req = 1'b1;
         repeat (4) @(negedge Clk);
         chk("bad_dir_no_ack", ack_cnt - a0, 0);
         chk("bad_dir_idle", fire.busy, 0);
         fire.fire_req = 1'b0;
      end

      // Right shot toward a target in its path.
      shoot(100, 380, 2, 200, 388, 1'b0, n, fx, fy);
      chk("t5_edges", n, HIT_EN ? 17 : 126);
      chk("t5_final_x", fx, HIT_EN ? 200 : 632);

      // Random shots.
      for (int k = 0; k < 6; k++) begin
         shoot(int'($urandom_range(0, 607)), int'($urandom_range(0, 447)),
               int'($urandom_range(1, 4)), int'($urandom_range(0, 607)),
               int'($urandom_range(0, 447)), k[0], n, fx, fy);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
